mac_rr_scheduler: RTL and testbench
===================================

Name: mac_rr_scheduler

Overview:
Shares one pipelined 5-operand MAC unit (result = a*b + c*d + e) between N_REQ requesters using round-robin arbitration. Issues at most one operation per cycle into the MAC and tracks the requester ID of each in-flight operation in an in-order tag FIFO. Routes each result back to its originating requester. Sits between the requester blocks and the MAC instance.

Parameters:
DATA_WIDTH, 32, operand/result width
N_REQ, 4, number of requesters (2..8)
TAG_DEPTH, 8, max in-flight operations; power of 2, >= MAC latency + 1
ID_W, $clog2(N_REQ), requester-ID width (derived)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester operation request
req_ready  out  N_REQ  per-requester accept; transfer = valid & ready
req_a, req_b, req_c, req_d, req_e  in  N_REQ*DATA_WIDTH each  packed operands; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
mac_start  out  1  issue strobe to MAC
mac_ready  in  1  MAC can accept this cycle
mac_a, mac_b, mac_c, mac_d, mac_e  out  DATA_WIDTH each  operands to MAC, valid with mac_start
mac_done  in  1  MAC result valid, one cycle per issued op, in issue order
mac_result  in  DATA_WIDTH  MAC result
rsp_valid  out  N_REQ  one-hot result strobe to requester
rsp_data  out  DATA_WIDTH  result data, valid with rsp_valid
inflight  out  $clog2(TAG_DEPTH)+1  current tag FIFO occupancy
idle  out  1  no request pending and inflight == 0
err_orphan  out  1  sticky: mac_done seen with empty tag FIFO

Behaviour:
- Reset (async assert, sync deassert) values: rr_ptr=0, tag FIFO empty, rsp_valid=0, rsp_data=0, err_orphan=0, inflight=0. Combinational outputs follow from the reset state: mac_start=0, req_ready=0, idle=1 when no req_valid.
- can_issue = mac_ready & (inflight < TAG_DEPTH). The check uses the pre-pop count, so a simultaneous pop does not free a slot in the same cycle.
- Arbitration is combinational: grant is the first asserted req_valid scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
- req_ready[i] = grant[i] & can_issue. At most one bit is set. req_ready never depends on req_ready of another requester.
- mac_start = |(grant) & can_issue. mac_a..e are muxed from the granted slice; they are don't-care when mac_start=0, and are driven from requester 0 in that case.
- On issue: push the granted ID into the tag FIFO; rr_ptr <= (granted ID + 1) mod N_REQ. With no issue, rr_ptr holds.
- Fairness: a continuously asserted requester is granted within N_REQ issue cycles.
- On mac_done with the FIFO non-empty: pop the head ID. Next cycle rsp_valid[ID]=1 and rsp_data=mac_result (1-cycle registered latency). rsp_valid is otherwise 0.
- No response backpressure: requesters must sink rsp_valid whenever it is asserted.
- Simultaneous push and pop in one cycle: both happen and inflight is unchanged.
- mac_done with an empty FIFO: no rsp_valid; err_orphan <= 1 and holds until reset.
- inflight increments on push only, decrements on pop only. Pointers wrap modulo TAG_DEPTH.
- Requester obligation: req_valid and operands stay stable until the transfer. The scheduler may re-arbitrate every cycle and does not latch a grant across cycles.
- Reset mid-operation: FIFO contents and pending responses are discarded. Results that arrive after reset with an empty FIFO set err_orphan, so the MAC must share the same reset.
- idle = ~|req_valid & (inflight == 0).

Test Plan:
- Single request: after reset, req_valid=0001, a=2, b=3, c=4, d=5, e=6 -> mac_start for 1 cycle with mac_a=2; req_ready[0]=1. MAC model with 5-cycle latency returns 32 -> rsp_valid=0001, rsp_data=32 one cycle after mac_done. inflight goes 0->1->0; idle returns to 1.
- Round-robin: all 4 requesters held valid for 8 cycles with mac_ready=1 -> grant order 0,1,2,3,0,1,2,3. Each requester receives exactly 2 rsp_valid pulses, in that order.
- Full stall: TAG_DEPTH=8, MAC model withholding mac_done -> after 8 issues, req_ready=0 and mac_start=0 with inflight=8. The first mac_done pops, but issue resumes only the cycle after the pop.
- mac_ready low: requester 2 valid, mac_ready=0 for 3 cycles -> no req_ready, rr_ptr unchanged. The issue happens on the first cycle mac_ready=1.
- Orphan: mac_done pulsed with an empty FIFO -> err_orphan=1 and stays 1, rsp_valid stays 0. Assert ap_rst_n=0 -> err_orphan=0 immediately, without waiting for a clock edge.
- Reset mid-flight: 3 ops issued, ap_rst_n pulsed low before any completes -> inflight=0, rsp_valid=0, rr_ptr=0. A new request from requester 1 issues normally.

Source files
------------

// File: rtl/mac_rr_scheduler_if.sv
// rtl/mac_rr_scheduler_if.sv - requester/MAC/response bundle for mac_rr_scheduler
//
// Purpose: groups every handshake and bus signal of the scheduler.
//   slave  modport: the scheduler itself
//   master modport: the requesters, the MAC and the status observer
// Signals:
//   req_valid/req_ready        per-requester issue handshake (N_REQ bits)
//   req_a..req_e               packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mac_start/mac_ready        issue strobe into the MAC and its accept
//   mac_a..mac_e               operands presented to the MAC with mac_start
//   mac_done/mac_result        in-order MAC completions
//   rsp_valid/rsp_data         one-hot result strobe and data back to requesters
//   inflight/idle/err_orphan   tag FIFO occupancy, quiescence, sticky orphan flag
interface mac_rr_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int TAG_DEPTH  = 8
);
  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] req_a;
  logic [N_REQ*DATA_WIDTH-1:0] req_b;
  logic [N_REQ*DATA_WIDTH-1:0] req_c;
  logic [N_REQ*DATA_WIDTH-1:0] req_d;
  logic [N_REQ*DATA_WIDTH-1:0] req_e;
  logic                        mac_start;
  logic                        mac_ready;
  logic [DATA_WIDTH-1:0]       mac_a;
  logic [DATA_WIDTH-1:0]       mac_b;
  logic [DATA_WIDTH-1:0]       mac_c;
  logic [DATA_WIDTH-1:0]       mac_d;
  logic [DATA_WIDTH-1:0]       mac_e;
  logic                        mac_done;
  logic [DATA_WIDTH-1:0]       mac_result;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_data;
  logic [CNT_W-1:0]            inflight;
  logic                        idle;
  logic                        err_orphan;

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_d, req_e,
    input  mac_ready, mac_done, mac_result,
    output req_ready, mac_start, mac_a, mac_b, mac_c, mac_d, mac_e,
    output rsp_valid, rsp_data, inflight, idle, err_orphan
  );

  modport master (
    output req_valid, req_a, req_b, req_c, req_d, req_e,
    output mac_ready, mac_done, mac_result,
    input  req_ready, mac_start, mac_a, mac_b, mac_c, mac_d, mac_e,
    input  rsp_valid, rsp_data, inflight, idle, err_orphan
  );
endinterface

// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - round-robin sharing of one pipelined MAC between N_REQ requesters
//
// Purpose: picks one requester per cycle (round-robin from r_rr_ptr), issues its
// operands to the MAC, remembers the requester ID in an in-order tag FIFO and
// routes each mac_done result back as a one-hot rsp_valid one cycle later.
// Ports:
//   ap_clk    clock
//   ap_rst_n  asynchronous active-low reset
//   bus       mac_rr_scheduler_if.slave (requester, MAC and response signals)
module mac_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ      = 4,
  parameter int TAG_DEPTH  = 8,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  mac_rr_scheduler_if.slave    bus
);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [N_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_err_orphan;

  logic                  w_grant_found;
  logic [ID_W-1:0]       w_grant_id;
  logic [ID_W:0]         w_cand;
  logic                  w_can_issue;
  logic                  w_issue;
  logic                  w_pop;

  // Scan rr_ptr, rr_ptr+1, ... (mod N_REQ); the extra bit in w_cand keeps the
  // wrap-around sum from overflowing before the modulo correction.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(N_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_grant_found && bus.req_valid[i] && (w_cand == (ID_W+1)'(i))) begin
          w_grant_found = 1'b1;
          w_grant_id    = ID_W'(i);
        end
      end
    end
  end

  // Occupancy check uses the pre-pop count: a pop this cycle frees a slot next cycle.
  assign w_can_issue = bus.mac_ready & (r_count < CNT_W'(TAG_DEPTH));
  assign w_issue     = w_grant_found & w_can_issue;
  assign w_pop       = bus.mac_done & (r_count != '0);

  assign bus.req_ready = w_issue ? (N_REQ'(1) << w_grant_id) : '0;
  assign bus.mac_start = w_issue;

  // Operand mux; with no grant w_grant_id is 0, so requester 0 is presented.
  always_comb begin
    bus.mac_a = bus.req_a[DATA_WIDTH-1:0];
    bus.mac_b = bus.req_b[DATA_WIDTH-1:0];
    bus.mac_c = bus.req_c[DATA_WIDTH-1:0];
    bus.mac_d = bus.req_d[DATA_WIDTH-1:0];
    bus.mac_e = bus.req_e[DATA_WIDTH-1:0];
    for (int i = 1; i < N_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        bus.mac_a = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        bus.mac_b = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
        bus.mac_c = bus.req_c[i*DATA_WIDTH +: DATA_WIDTH];
        bus.mac_d = bus.req_d[i*DATA_WIDTH +: DATA_WIDTH];
        bus.mac_e = bus.req_e[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_issue) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_grant_id == ID_W'(N_REQ-1)) ? '0 : w_grant_id + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_rsp_data <= bus.mac_result;
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rsp_valid <= w_pop ? (N_REQ'(1) << r_tag_mem[r_rd_ptr]) : '0;
      if (bus.mac_done && (r_count == '0)) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  // Tag storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge ap_clk) begin
    if (w_issue) begin
      r_tag_mem[r_wr_ptr] <= w_grant_id;
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.inflight   = r_count;
  assign bus.idle       = ~|bus.req_valid & (r_count == '0);
  assign bus.err_orphan = r_err_orphan;
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb/tb_mac_rr_scheduler.sv - directed self-checking bench for mac_rr_scheduler
module tb_mac_rr_scheduler;
  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int TD  = 8;
  localparam int LAT = 5;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  mac_rr_scheduler_if #(.DATA_WIDTH(DW), .N_REQ(N), .TAG_DEPTH(TD)) bus ();

  mac_rr_scheduler #(.DATA_WIDTH(DW), .N_REQ(N), .TAG_DEPTH(TD)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: round-robin pointer as an integer, tag FIFO as queues.
  int          m_rr;
  int          m_tag [$];
  logic [DW-1:0] m_res [$];
  logic [N-1:0]  m_rsp_valid;
  logic [DW-1:0] m_rsp_data;
  logic          m_err;
  int            grant_log [$];
  int            rsp_cnt [N];

  // MAC model: fixed latency, completions in order.
  logic [DW-1:0] mq_res [$];
  int            mq_due [$];
  int            cyc;
  bit            mac_hold;
  bit            orphan_pulse;

  function automatic logic [DW-1:0] opnd(logic [N*DW-1:0] v, int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] mac_fn(logic [DW-1:0] a, logic [DW-1:0] b,
                                           logic [DW-1:0] c, logic [DW-1:0] d,
                                           logic [DW-1:0] e);
    return a * b + c * d + e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0;
    m_tag.delete();
    m_res.delete();
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    m_err       = 1'b0;
    mq_res.delete();
    mq_due.delete();
  endtask

  task automatic set_ops(int i, logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c,
                         logic [DW-1:0] d, logic [DW-1:0] e);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
    bus.req_c[i*DW +: DW] = c;
    bus.req_d[i*DW +: DW] = d;
    bus.req_e[i*DW +: DW] = e;
  endtask

  // One cycle: compare at the falling edge, drive MAC outputs for the next
  // rising edge, advance the model, return just after the rising edge.
  task automatic tick();
    int gid;
    int id;
    bit can;
    bit issue;
    bit done;
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] res;
    @(negedge ap_clk);
    cyc++;
    if (!ap_rst_n) model_reset();
    can = bus.mac_ready && (m_tag.size() < TD);
    gid = -1;
    for (int k = 0; k < N; k++) begin
      if (gid < 0 && bus.req_valid[(m_rr + k) % N]) gid = (m_rr + k) % N;
    end
    issue = can && (gid >= 0);
    exp_ready = issue ? (N'(1) << gid) : '0;
    chk("req_ready", bus.req_ready, exp_ready);
    chk("mac_start", bus.mac_start, issue);
    chk("inflight", bus.inflight, m_tag.size());
    chk("idle", bus.idle, (bus.req_valid == '0) && (m_tag.size() == 0));
    chk("rsp_valid", bus.rsp_valid, m_rsp_valid);
    if (m_rsp_valid != '0 || !ap_rst_n) chk("rsp_data", bus.rsp_data, m_rsp_data);
    chk("err_orphan", bus.err_orphan, m_err);
    if (issue) begin
      chk("mac_a", bus.mac_a, opnd(bus.req_a, gid));
      chk("mac_b", bus.mac_b, opnd(bus.req_b, gid));
      chk("mac_c", bus.mac_c, opnd(bus.req_c, gid));
      chk("mac_d", bus.mac_d, opnd(bus.req_d, gid));
      chk("mac_e", bus.mac_e, opnd(bus.req_e, gid));
    end
    if (!ap_rst_n) begin
      bus.mac_done   = 1'b0;
      bus.mac_result = '0;
    end else begin
      if (bus.mac_start && bus.mac_ready) begin
        mq_res.push_back(mac_fn(bus.mac_a, bus.mac_b, bus.mac_c, bus.mac_d, bus.mac_e));
        mq_due.push_back(cyc + LAT);
      end
      done = 1'b0;
      res  = '0;
      if (orphan_pulse) begin
        done = 1'b1;
        res  = 32'hDEAD_BEEF;
        orphan_pulse = 1'b0;
      end else if (!mac_hold && mq_due.size() > 0 && mq_due[0] <= cyc) begin
        done = 1'b1;
        res  = mq_res.pop_front();
        void'(mq_due.pop_front());
      end
      bus.mac_done   = done;
      bus.mac_result = res;
      m_rsp_valid = '0;
      if (done) begin
        if (m_tag.size() > 0) begin
          id = m_tag.pop_front();
          m_rsp_valid = N'(1) << id;
          m_rsp_data  = m_res.pop_front();
          rsp_cnt[id]++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (issue) begin
        m_tag.push_back(gid);
        m_res.push_back(mac_fn(opnd(bus.req_a, gid), opnd(bus.req_b, gid), opnd(bus.req_c, gid),
                               opnd(bus.req_d, gid), opnd(bus.req_e, gid)));
        m_rr = (gid + 1) % N;
        grant_log.push_back(gid);
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
    grant_log.delete();
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (bus.inflight != '0 || bus.rsp_valid != '0); i++) tick();
    chk("drain_inflight", bus.inflight, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    ap_rst_n       = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_c      = '0;
    bus.req_d      = '0;
    bus.req_e      = '0;
    bus.mac_ready  = 1'b0;
    bus.mac_done   = 1'b0;
    bus.mac_result = '0;
    mac_hold       = 1'b0;
    orphan_pulse   = 1'b0;
    cyc            = 0;
    model_reset();
    #3;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_err", bus.err_orphan, 0);
    chk("rst_idle", bus.idle, 1);
    chk("rst_mac_start", bus.mac_start, 0);
    do_reset();

    // Single request: 2*3 + 4*5 + 6 = 32
    set_ops(0, 2, 3, 4, 5, 6);
    bus.mac_ready = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    chk("single_start", bus.mac_start, 1);
    chk("single_mac_a", bus.mac_a, 2);
    chk("single_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    chk("single_inflight1", bus.inflight, 1);
    for (int i = 0; i < 20 && bus.rsp_valid == '0; i++) tick();
    chk("single_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("single_rsp_data", bus.rsp_data, 32);
    chk("single_inflight0", bus.inflight, 0);
    chk("single_idle", bus.idle, 1);
    tick();

    // Round-robin with all requesters held valid
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, i + 1, 10, i, 2, 100 * i);
    bus.mac_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    bus.req_valid = '0;
    drain();
    chk("rr_grant_count", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size(); k++) chk("rr_grant_order", grant_log[k], k % 4);
    for (int i = 0; i < N; i++) chk("rr_rsp_count", rsp_cnt[i], 2);

    // Full stall with completions withheld
    do_reset();
    mac_hold = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) tick();
    chk("stall_inflight8", bus.inflight, 8);
    chk("stall_ready", bus.req_ready, 0);
    chk("stall_start", bus.mac_start, 0);
    tick();
    tick();
    chk("stall_still8", bus.inflight, 8);
    mac_hold = 1'b0;
    tick();
    chk("stall_pop_inflight", bus.inflight, 7);
    chk("stall_resume", bus.mac_start, 1);
    bus.req_valid = '0;
    drain();

    // mac_ready low holds off requester 2 without moving the pointer
    do_reset();
    set_ops(2, 7, 8, 9, 10, 11);
    bus.req_valid = 4'b0100;
    bus.mac_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mrdy_ready0", bus.req_ready, 0);
    chk("mrdy_start0", bus.mac_start, 0);
    bus.mac_ready = 1'b1;
    #1;
    chk("mrdy_ready2", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b1011;
    #1;
    chk("mrdy_next_ptr3", bus.req_ready, 4'b1000);
    bus.req_valid = '0;
    drain();
    chk("mrdy_rsp2", rsp_cnt[2], 1);

    // Orphan completion, then asynchronous clear by reset
    orphan_pulse = 1'b1;
    tick();
    chk("orphan_set", bus.err_orphan, 1);
    chk("orphan_no_rsp", bus.rsp_valid, 0);
    tick();
    tick();
    chk("orphan_sticky", bus.err_orphan, 1);
    ap_rst_n = 1'b0;
    #1;
    chk("orphan_async_clear", bus.err_orphan, 0);
    tick();
    ap_rst_n = 1'b1;

    // Reset with three operations in flight
    bus.mac_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    bus.req_valid = '0;
    chk("mid_inflight3", bus.inflight, 3);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_inflight0", bus.inflight, 0);
    chk("mid_rsp_valid0", bus.rsp_valid, 0);
    tick();
    ap_rst_n = 1'b1;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    bus.req_valid = 4'b1001;
    #1;
    chk("mid_ptr0", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b0010;
    #1;
    chk("mid_req1_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    drain();
    chk("mid_req1_rsp", rsp_cnt[1], 1);
    chk("mid_no_orphan", bus.err_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
